// File: rtl/wb_pkg.sv
// wb_pkg: writeback source encoding, entry layout and source count shared by the arbiter
package wb_pkg;
  localparam int NUM_WB_SRC = 3;
  localparam int WB_DW = 32;
  localparam int WB_AW = 5;
  typedef enum logic [1:0] {NONE = 2'd0, ALU = 2'd1, MDU = 2'd2, LSU = 2'd3} wb_src_e;
  typedef struct packed {
    logic [WB_AW-1:0] waddr;
    logic [WB_DW-1:0] wdata;
  } wb_entry_t;
endpackage

// File: rtl/wb_src_buf.sv
// wb_src_buf: one-entry result buffer with wait-age counter and valid/ready handshake
module wb_src_buf
  import wb_pkg::*;
#(
  parameter int DW = WB_DW,
  parameter int AW = WB_AW,
  parameter int AGE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] waddr,
  input  logic         grant,
  output logic         ready,
  output logic         buf_valid,
  output logic         aged,
  output logic [AW+DW-1:0] entry
);
  localparam int CW = $clog2(AGE_MAX + 1);
  localparam logic [CW-1:0] AGE_TOP = CW'(AGE_MAX);
  logic [CW-1:0] age;
  logic load;
  assign ready = ~buf_valid | grant;
  assign load = valid & ready & (|waddr);
  assign aged = buf_valid & (age == AGE_TOP);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      buf_valid <= 1'b0;
      age <= '0;
      entry <= '0;
    end else begin
      buf_valid <= load | (buf_valid & ~grant);
      age <= (~buf_valid | grant) ? '0 : (age == AGE_TOP) ? age : age + 1'b1;
      if (load) entry <= {waddr, wdata};
    end
endmodule

// File: rtl/exu_wb_arbiter.sv
// exu_wb_arbiter: buffers ALU/MDU/LSU results and grants one register-file write per cycle
module exu_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DW = WB_DW,
  parameter int AW = WB_AW,
  parameter int AGE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid_i,
  input  logic [DW-1:0] alu_wdata_i,
  input  logic [AW-1:0] alu_waddr_i,
  output logic          alu_ready_o,
  input  logic          mdu_valid_i,
  input  logic [DW-1:0] mdu_wdata_i,
  input  logic [AW-1:0] mdu_waddr_i,
  output logic          mdu_ready_o,
  input  logic          lsu_valid_i,
  input  logic [DW-1:0] lsu_wdata_i,
  input  logic [AW-1:0] lsu_waddr_i,
  output logic          lsu_ready_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_waddr_o,
  output logic [DW-1:0] wb_wdata_o,
  output logic [1:0]    wb_src_o
);
  logic [NUM_WB_SRC-1:0] valid, ready, buf_valid, aged, grant, pick;
  logic [DW-1:0] wdata [NUM_WB_SRC];
  logic [AW-1:0] waddr [NUM_WB_SRC];
  logic [AW+DW-1:0] entry [NUM_WB_SRC];
  logic [AW+DW-1:0] sel_entry;
  wb_src_e sel_src;
  assign valid = {lsu_valid_i, mdu_valid_i, alu_valid_i};
  assign wdata = '{alu_wdata_i, mdu_wdata_i, lsu_wdata_i};
  assign waddr = '{alu_waddr_i, mdu_waddr_i, lsu_waddr_i};
  assign {lsu_ready_o, mdu_ready_o, alu_ready_o} = ready;
  for (genvar i = 0; i < NUM_WB_SRC; i++) begin : g_buf
    wb_src_buf #(.DW(DW), .AW(AW), .AGE_MAX(AGE_MAX)) u_buf (
      .clk(clk),
      .rst(rst),
      .valid(valid[i]),
      .wdata(wdata[i]),
      .waddr(waddr[i]),
      .grant(grant[i]),
      .ready(ready[i]),
      .buf_valid(buf_valid[i]),
      .aged(aged[i]),
      .entry(entry[i])
    );
  end
  always_comb begin
    pick = |aged ? aged : buf_valid;
    grant = pick[2] ? 3'b100 : pick[1] ? 3'b010 : pick[0] ? 3'b001 : 3'b000;
    sel_src = pick[2] ? LSU : pick[1] ? MDU : pick[0] ? ALU : NONE;
    sel_entry = pick[2] ? entry[2] : pick[1] ? entry[1] : entry[0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wb_we_o <= 1'b0;
      wb_src_o <= '0;
      wb_waddr_o <= '0;
      wb_wdata_o <= '0;
    end else begin
      wb_we_o <= |grant;
      wb_src_o <= sel_src;
      if (|grant) {wb_waddr_o, wb_wdata_o} <= sel_entry;
    end
endmodule

// File: tb/tb_exu_wb_arbiter.sv
// tb_exu_wb_arbiter: table vectors, corner sequences and random traffic against an age-by-timestamp model
module tb_exu_wb_arbiter;
  localparam int AGE_MAX = 4;
  typedef struct packed {
    logic [2:0] v;
    logic [2:0][4:0] a;
    logic we;
    logic [1:0] src;
    logic [4:0] wa;
    logic [2:0] rdy;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic alu_valid_i = 1'b0, mdu_valid_i = 1'b0, lsu_valid_i = 1'b0;
  logic [31:0] alu_wdata_i = '0, mdu_wdata_i = '0, lsu_wdata_i = '0;
  logic [4:0] alu_waddr_i = '0, mdu_waddr_i = '0, lsu_waddr_i = '0;
  logic alu_ready_o, mdu_ready_o, lsu_ready_o, wb_we_o;
  logic [4:0] wb_waddr_o;
  logic [31:0] wb_wdata_o;
  logic [1:0] wb_src_o;
  logic [2:0] in_v;
  logic [4:0] in_a [3];
  logic [31:0] in_d [3];
  bit m_occ [3];
  int m_fill [3];
  logic [4:0] m_addr [3];
  logic [31:0] m_data [3];
  int cyc;
  logic exp_we;
  logic [1:0] exp_src;
  logic [4:0] exp_addr;
  logic [31:0] exp_data;
  logic [2:0] exp_rdy;
  int n_cmp = 0, n_bad = 0;
  vec_t vt [$];
  logic [4:0] next_lsu;
  int alu_cyc;
  exu_wb_arbiter #(.DW(32), .AW(5), .AGE_MAX(AGE_MAX)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_i(alu_valid_i), .alu_wdata_i(alu_wdata_i), .alu_waddr_i(alu_waddr_i), .alu_ready_o(alu_ready_o),
    .mdu_valid_i(mdu_valid_i), .mdu_wdata_i(mdu_wdata_i), .mdu_waddr_i(mdu_waddr_i), .mdu_ready_o(mdu_ready_o),
    .lsu_valid_i(lsu_valid_i), .lsu_wdata_i(lsu_wdata_i), .lsu_waddr_i(lsu_waddr_i), .lsu_ready_o(lsu_ready_o),
    .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o), .wb_src_o(wb_src_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_occ[i] = 0;
    exp_we = 0;
    exp_src = 0;
    exp_addr = 0;
    exp_data = 0;
  endtask
  // Check outputs of the current cycle against the model, drive inputs, advance the model.
  task automatic step();
    int gi;
    bit any_aged;
    @(negedge clk);
    gi = -1;
    any_aged = 0;
    for (int i = 0; i < 3; i++) if (m_occ[i] && cyc - m_fill[i] >= AGE_MAX) any_aged = 1;
    for (int i = 0; i < 3; i++) if (m_occ[i] && (!any_aged || cyc - m_fill[i] >= AGE_MAX)) gi = i;
    for (int i = 0; i < 3; i++) exp_rdy[i] = !m_occ[i] || gi == i;
    chk("ready", {lsu_ready_o, mdu_ready_o, alu_ready_o}, exp_rdy);
    chk("we", wb_we_o, exp_we);
    chk("src", wb_src_o, exp_src);
    if (exp_we) begin
      chk("waddr", wb_waddr_o, exp_addr);
      chk("wdata", wb_wdata_o, exp_data);
    end
    alu_valid_i = in_v[0]; alu_waddr_i = in_a[0]; alu_wdata_i = in_d[0];
    mdu_valid_i = in_v[1]; mdu_waddr_i = in_a[1]; mdu_wdata_i = in_d[1];
    lsu_valid_i = in_v[2]; lsu_waddr_i = in_a[2]; lsu_wdata_i = in_d[2];
    if (gi >= 0) begin
      exp_we = 1; exp_src = 2'(gi + 1); exp_addr = m_addr[gi]; exp_data = m_data[gi];
    end else begin
      exp_we = 0; exp_src = 0;
    end
    for (int i = 0; i < 3; i++)
      if (in_v[i] && exp_rdy[i] && in_a[i] != 0) begin
        m_occ[i] = 1; m_fill[i] = cyc + 1; m_addr[i] = in_a[i]; m_data[i] = in_d[i];
      end else if (gi == i) m_occ[i] = 0;
    cyc++;
  endtask
  function automatic vec_t mk(logic [2:0] v, logic [4:0] a2, logic [4:0] a1, logic [4:0] a0,
                              logic we, logic [1:0] src, logic [4:0] wa, logic [2:0] rdy);
    vec_t t;
    t.v = v; t.a = {a2, a1, a0}; t.we = we; t.src = src; t.wa = wa; t.rdy = rdy;
    return t;
  endfunction
  task automatic run_tbl();
    foreach (vt[k]) begin
      in_v = vt[k].v;
      for (int i = 0; i < 3; i++) begin
        in_a[i] = vt[k].a[i];
        in_d[i] = 32'(vt[k].a[i]) << 4;
      end
      step();
      chk("tbl_we", wb_we_o, vt[k].we);
      chk("tbl_src", wb_src_o, vt[k].src);
      chk("tbl_ready", {lsu_ready_o, mdu_ready_o, alu_ready_o}, vt[k].rdy);
      if (vt[k].we) begin
        chk("tbl_waddr", wb_waddr_o, vt[k].wa);
        chk("tbl_wdata", wb_wdata_o, 32'(vt[k].wa) << 4);
      end
    end
    vt.delete();
  endtask
  initial begin
    cyc = 0;
    in_v = 0;
    for (int i = 0; i < 3; i++) begin in_a[i] = 0; in_d[i] = 0; end
    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_we", wb_we_o, 0);
    chk("reset_src", wb_src_o, 0);
    chk("reset_waddr", wb_waddr_o, 0);
    chk("reset_wdata", wb_wdata_o, 0);
    rst = 1'b0;
    for (int c = 0; c < 11; c++)
      vt.push_back(mk(c < 8 ? 3'b001 : 3'b000, 0, 0, 5'(c + 5), c >= 2 && c <= 9,
                      (c >= 2 && c <= 9) ? 2'd1 : 2'd0, 5'(c + 3), 3'b111));
    run_tbl();
    vt.push_back(mk(3'b111, 3, 2, 1, 0, 0, 0, 3'b111));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b100));
    vt.push_back(mk(3'b000, 0, 0, 0, 1, 3, 3, 3'b110));
    vt.push_back(mk(3'b000, 0, 0, 0, 1, 2, 2, 3'b111));
    vt.push_back(mk(3'b000, 0, 0, 0, 1, 1, 1, 3'b111));
    vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b111));
    run_tbl();
    repeat (3) vt.push_back(mk(3'b001, 0, 0, 0, 0, 0, 0, 3'b111));
    repeat (2) vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b111));
    run_tbl();
    next_lsu = 16;
    alu_cyc = -1;
    for (int c = 0; c < 12; c++) begin
      in_v = {1'b1, 1'b0, c == 0};
      in_a[0] = 7; in_d[0] = 32'h700;
      in_a[1] = 0; in_d[1] = 0;
      in_a[2] = next_lsu; in_d[2] = 32'(next_lsu) << 4;
      step();
      if (exp_rdy[2]) next_lsu++;
      if (wb_src_o == 2'd1 && alu_cyc < 0) alu_cyc = c;
      else if (alu_cyc >= 0 && c == alu_cyc + 1) chk("age_next_src", wb_src_o, 2'd3);
    end
    chk("age_alu_write_cycle", alu_cyc, 6);
    in_v = 0;
    repeat (4) step();
    in_v = 3'b111;
    in_a[0] = 9; in_a[1] = 10; in_a[2] = 11;
    for (int i = 0; i < 3; i++) in_d[i] = 32'(in_a[i]) << 4;
    step();
    in_v = 0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("midrst_we", wb_we_o, 0);
    chk("midrst_src", wb_src_o, 0);
    chk("midrst_ready", {lsu_ready_o, mdu_ready_o, alu_ready_o}, 3'b111);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b111));
    run_tbl();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        in_v[i] = $urandom_range(0, 9) < 6;
        in_a[i] = 5'($urandom_range(0, 31));
        in_d[i] = $urandom;
      end
      step();
    end
    in_v = 0;
    repeat (6) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
